// File: rtl/dmem_port_if.sv
// Request/response port of the data-memory access controller.
// The master side issues loads/stores; the slave side is the controller.
interface dmem_port_if #(
  parameter int ADDR_W = 64
) ();
  logic              valid;
  logic              ready;
  logic              we;
  logic [1:0]        size;
  logic              sext;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       wdata;
  logic              rsp;
  logic [63:0]       rdata;
  logic              err;

  modport master (
    output valid, we, size, sext, addr, wdata,
    input  ready, rsp, rdata, err
  );

  modport slave (
    input  valid, we, size, sext, addr, wdata,
    output ready, rsp, rdata, err
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Two-port round-robin sequencer in front of a big-endian 64-bit data memory.
// Sub-word stores are done as read-modify-write so the memory only sees 8-byte accesses.
module dmem_access_ctrl #(
  parameter int MEM_BYTES = 8192,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  dmem_port_if.slave        p0,
  dmem_port_if.slave        p1,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [63:0]       mem_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_t      state, next_state;
  logic        rr_ptr, gnt;
  logic        l_we, l_sext, err_q;
  logic [1:0]  l_size;
  logic [63:0] l_wdata;
  logic [55:0] rd_word;
  logic [63:0] rdata0, rdata1;

  logic              any_valid, both_valid, sel;
  logic              s_we, s_sext, oor;
  logic [1:0]        s_size;
  logic [ADDR_W-1:0] s_addr;
  logic [63:0]       s_wdata, wbus;
  logic [3:0]        nbytes;
  logic              drive_en;

  function automatic logic [63:0] extract(input logic [63:0] w, input logic [1:0] sz,
                                          input logic sx);
    logic [63:0] v;
    case (sz)
      2'd0:    v = sx ? {{56{w[63]}}, w[63:56]} : {56'b0, w[63:56]};
      2'd1:    v = sx ? {{48{w[63]}}, w[63:48]} : {48'b0, w[63:48]};
      2'd2:    v = sx ? {{32{w[63]}}, w[63:32]} : {32'b0, w[63:32]};
      default: v = w;
    endcase
    return v;
  endfunction

  // Arbitration and selection of the request presented this cycle.
  always_comb begin
    any_valid  = p0.valid | p1.valid;
    both_valid = p0.valid & p1.valid;
    sel        = both_valid ? rr_ptr : p1.valid;
    s_we       = sel ? p1.we    : p0.we;
    s_size     = sel ? p1.size  : p0.size;
    s_sext     = sel ? p1.sext  : p0.sext;
    s_addr     = sel ? p1.addr  : p0.addr;
    s_wdata    = sel ? p1.wdata : p0.wdata;
    nbytes     = 4'd1 << s_size;
    // 65-bit sum so an address near the top of the space cannot wrap past the check.
    oor        = ({1'b0, s_addr} + {{(ADDR_W-3){1'b0}}, nbytes}) > MEM_LIMIT;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (any_valid) begin
          if (oor)                        next_state = DONE;
          else if (!s_we || s_size != 2'd3) next_state = RD;
          else                            next_state = WR;
        end
      end
      RD:      next_state = l_we ? WR : DONE;
      WR:      next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    p0.ready = rst && (state == IDLE) && any_valid && !sel;
    p1.ready = rst && (state == IDLE) && any_valid &&  sel;
    p0.rsp   = (state == DONE) && !gnt;
    p1.rsp   = (state == DONE) &&  gnt;
    p0.err   = (state == DONE) && !gnt && err_q;
    p1.err   = (state == DONE) &&  gnt && err_q;
    p0.rdata = rdata0;
    p1.rdata = rdata1;
  end

  always_comb begin
    case (l_size)
      2'd0:    wbus = {l_wdata[7:0],  rd_word[55:0]};
      2'd1:    wbus = {l_wdata[15:0], rd_word[47:0]};
      2'd2:    wbus = {l_wdata[31:0], rd_word[31:0]};
      default: wbus = l_wdata;
    endcase
  end

  assign drive_en = mem_rw && (state == WR);
  assign mem_data = drive_en ? wbus : 'z;

  always_comb begin
    if (!mem_rw) assert (!drive_en);
  end

  // mem_rw is registered from next_state so it is high for exactly the WR cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      gnt      <= 1'b0;
      l_we     <= 1'b0;
      l_sext   <= 1'b0;
      l_size   <= 2'd0;
      l_wdata  <= '0;
      err_q    <= 1'b0;
      rd_word  <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
      mem_rw   <= 1'b0;
      mem_addr <= '0;
    end else begin
      state  <= next_state;
      mem_rw <= (next_state == WR);
      case (state)
        IDLE: begin
          if (any_valid) begin
            gnt     <= sel;
            l_we    <= s_we;
            l_size  <= s_size;
            l_sext  <= s_sext;
            l_wdata <= s_wdata;
            err_q   <= oor;
            if (both_valid) rr_ptr <= ~rr_ptr;
            if (!oor)       mem_addr <= s_addr;
          end
        end
        RD: begin
          rd_word <= mem_data[55:0];
          if (!l_we) begin
            if (gnt) rdata1 <= extract(mem_data, l_size, l_sext);
            else     rdata0 <= extract(mem_data, l_size, l_sext);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl with a byte-array model of the data memory.
module tb_dmem_access_ctrl;
  localparam int MEM_BYTES = 8192;
  localparam int ADDR_W    = 64;

  logic              clk;
  logic              rst;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  wire  [63:0]       mem_data;

  dmem_port_if #(.ADDR_W(ADDR_W)) p0 ();
  dmem_port_if #(.ADDR_W(ADDR_W)) p1 ();

  dmem_access_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .p0       (p0),
    .p1       (p1),
    .mem_rw   (mem_rw),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational big-endian read, negedge write, out-of-range bytes read 0.
  logic [7:0]  mem [0:MEM_BYTES-1];
  logic [63:0] rword;

  always_comb begin
    rword = '0;
    for (int i = 0; i < 8; i++)
      if (mem_addr + 64'(i) < 64'(MEM_BYTES))
        rword[63-8*i -: 8] = mem[13'(mem_addr + 64'(i))];
  end

  assign mem_data = (!mem_rw && rst) ? rword : 'z;

  always @(negedge clk) begin
    if (mem_rw)
      for (int i = 0; i < 8; i++)
        if (mem_addr + 64'(i) < 64'(MEM_BYTES))
          mem[13'(mem_addr + 64'(i))] <= mem_data[63-8*i -: 8];
  end

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic        chk_rdata;
    logic        is_store;
    int          exp_cyc;
    int          wr_base;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   glog[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wr_count = 0;
  int   last_wr_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_rsp(input int port);
    exp_t e;
    if ((port == 0 && q0.size() == 0) || (port == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected rsp on port %0d at cycle %0d", port, cyc);
      return;
    end
    e = (port == 0) ? q0.pop_front() : q1.pop_front();
    check_output({e.name, " rsp cycle"}, 64'(cyc), 64'(e.exp_cyc));
    check_output({e.name, " err"}, {63'b0, (port == 0) ? p0.err : p1.err}, {63'b0, e.err});
    if (e.chk_rdata)
      check_output({e.name, " rdata"}, (port == 0) ? p0.rdata : p1.rdata, e.rdata);
    check_output({e.name, " write count"}, 64'(wr_count), 64'(e.wr_base + (e.is_store ? 1 : 0)));
    if (e.is_store)
      check_output({e.name, " write cycle"}, 64'(last_wr_cyc), 64'(e.exp_cyc - 1));
  endtask

  // Monitor: counts memory writes, logs grants and scores every response pulse.
  always @(negedge clk) begin
    if (mem_rw) begin
      wr_count++;
      last_wr_cyc = cyc;
    end
    if (p0.ready && p1.ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL double ready at cycle %0d", cyc);
    end
    if (p0.ready) glog.push_back(0);
    if (p1.ready) glog.push_back(1);
    if (p0.rsp) check_rsp(0);
    if (p1.rsp) check_rsp(1);
  end

  function automatic logic rdy(input int port);
    return (port == 0) ? p0.ready : p1.ready;
  endfunction

  task automatic apply_stimulus(input int port, input logic we, input logic [1:0] size,
                                input logic sext, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [63:0] exp_rdata,
                                input logic exp_err, input int lat, input string name);
    exp_t e;
    bit   acc = 0;
    @(posedge clk);
    #1;
    if (port == 0) begin
      p0.we = we; p0.size = size; p0.sext = sext; p0.addr = addr; p0.wdata = wdata;
      p0.valid = 1'b1;
    end else begin
      p1.we = we; p1.size = size; p1.sext = sext; p1.addr = addr; p1.wdata = wdata;
      p1.valid = 1'b1;
    end
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      if (rdy(port)) acc = 1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s accept timeout", name);
    end else begin
      e.rdata     = exp_rdata;
      e.err       = exp_err;
      e.chk_rdata = !we && !exp_err;
      e.is_store  = we && !exp_err;
      e.exp_cyc   = cyc + lat;
      e.wr_base   = wr_count;
      e.name      = name;
      if (port == 0) q0.push_back(e);
      else           q1.push_back(e);
      @(posedge clk);
      #1;
    end
    if (port == 0) p0.valid = 1'b0;
    else           p1.valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 40 && (q0.size() != 0 || q1.size() != 0); n++) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL response timeout, %0d/%0d outstanding", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit acc;
    for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
    rst = 1'b0;
    p0.valid = 0; p0.we = 0; p0.size = 0; p0.sext = 0; p0.addr = 0; p0.wdata = 0;
    p1.valid = 0; p1.we = 0; p1.size = 0; p1.sext = 0; p1.addr = 0; p1.wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset p0 ready", {63'b0, p0.ready}, 64'd0);
    check_output("reset p1 ready", {63'b0, p1.ready}, 64'd0);
    check_output("reset p0 rsp",   {63'b0, p0.rsp},   64'd0);
    check_output("reset p1 err",   {63'b0, p1.err},   64'd0);
    check_output("reset p0 rdata", p0.rdata, 64'd0);
    check_output("reset p1 rdata", p1.rdata, 64'd0);
    check_output("reset mem_rw",   {63'b0, mem_rw},   64'd0);
    check_output("reset mem_addr", mem_addr, 64'd0);
    rst = 1'b1;

    apply_stimulus(0, 1, 3, 0, 64'h10, 64'h0C3C3EAAF00FCC33, 0, 0, 2, "t1 st8");
    wait_done();
    apply_stimulus(0, 0, 3, 0, 64'h10, 0, 64'h0C3C3EAAF00FCC33, 0, 2, "t1 ld8");
    wait_done();
    check_output("t1 mem[0x10]", {56'b0, mem[16'h10]}, 64'h0C);
    check_output("t1 mem[0x17]", {56'b0, mem[16'h17]}, 64'h33);

    apply_stimulus(0, 1, 0, 0, 64'h12, 64'hA5, 0, 0, 3, "t2 st1");
    wait_done();
    apply_stimulus(0, 0, 3, 0, 64'h10, 0, 64'h0C3CA5AAF00FCC33, 0, 2, "t2 ld8");
    wait_done();

    apply_stimulus(0, 0, 1, 1, 64'h14, 0, 64'hFFFFFFFFFFFFF00F, 0, 2, "t3 ld2 sext");
    wait_done();
    apply_stimulus(0, 0, 1, 0, 64'h14, 0, 64'h000000000000F00F, 0, 2, "t3 ld2 zext");
    wait_done();

    glog.delete();
    fork
      begin
        apply_stimulus(0, 0, 3, 0, 64'h10, 0, 64'h0C3CA5AAF00FCC33, 0, 2, "t4 p0 ld8");
        apply_stimulus(0, 0, 2, 0, 64'h10, 0, 64'h000000000C3CA5AA, 0, 2, "t4 p0 ld4");
      end
      begin
        apply_stimulus(1, 1, 2, 0, 64'h20, 64'hDEADBEEF, 0, 0, 3, "t4 p1 st4");
        apply_stimulus(1, 0, 2, 1, 64'h20, 0, 64'hFFFFFFFFDEADBEEF, 0, 2, "t4 p1 ld4");
      end
    join
    wait_done();
    check_output("t4 grant count", 64'(glog.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check_output($sformatf("t4 grant %0d", i),
                   (i < glog.size()) ? 64'(glog[i]) : 64'hFFFF, 64'(i % 2));

    apply_stimulus(0, 0, 3, 0, 64'(MEM_BYTES - 7), 0, 0, 1, 1, "t5 ld8 oor");
    wait_done();
    apply_stimulus(0, 1, 0, 0, 64'(MEM_BYTES - 1), 64'h5A, 0, 0, 3, "t5 st1 last");
    wait_done();
    check_output("t5 last byte", {56'b0, mem[MEM_BYTES-1]}, 64'h5A);
    apply_stimulus(0, 0, 0, 0, 64'(MEM_BYTES - 1), 0, 64'h5A, 0, 2, "t5 ld1 last");
    wait_done();

    // Abort a sub-word store by resetting in the first half of its WR cycle.
    @(posedge clk);
    #1;
    p0.we = 1; p0.size = 0; p0.sext = 0; p0.addr = 64'h30; p0.wdata = 64'h77; p0.valid = 1;
    acc = 0;
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      if (p0.ready) acc = 1;
    end
    check_output("t6 accepted", {63'b0, acc}, 64'd1);
    @(posedge clk);
    #1;
    p0.valid = 0;
    @(posedge clk);
    #1;
    check_output("t6 mem_rw in WR", {63'b0, mem_rw}, 64'd1);
    rst = 1'b0;
    #1;
    check_output("t6 mem_rw after rst", {63'b0, mem_rw}, 64'd0);
    check_output("t6 mem_addr after rst", mem_addr, 64'd0);
    @(negedge clk);
    #1;
    check_output("t6 mem[0x30] unchanged", {56'b0, mem[16'h30]}, 64'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply_stimulus(0, 1, 0, 0, 64'h30, 64'h77, 0, 0, 3, "t6 st1 after rst");
    wait_done();
    apply_stimulus(0, 0, 0, 0, 64'h30, 0, 64'h77, 0, 2, "t6 ld1 after rst");
    wait_done();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequencer and two-port arbiter in front of the 64-bit, byte-addressed, big-endian data memory (combinational read, negedge write, shared inout data bus, mem_rw=1 means write). Port 0 serves the CPU load/store unit and port 1 serves the debug/DMA loader. Both ports share the single memory through round-robin arbitration. Stores narrower than 64 bits are executed as read-modify-write, so the memory only ever sees full 8-byte accesses.

Parameters:
MEM_BYTES, 8192, memory size in bytes; valid access requires addr+nbytes <= MEM_BYTES
ADDR_W, 64, address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
p0_valid, p1_valid  in  1  request valid; held stable until accepted
p0_ready, p1_ready  out  1  request accepted this cycle (valid & ready)
p0_we, p1_we  in  1  1 = store, 0 = load
p0_size, p1_size  in  2  0=1B, 1=2B, 2=4B, 3=8B (nbytes = 1<<size)
p0_sext, p1_sext  in  1  load sign-extend enable
p0_addr, p1_addr  in  ADDR_W  byte address
p0_wdata, p1_wdata  in  64  store value, right-aligned
p0_rsp, p1_rsp  out  1  one-cycle response pulse
p0_rdata, p1_rdata  out  64  load result, valid with the rsp pulse; holds its value otherwise
p0_err, p1_err  out  1  out-of-range flag, valid with the rsp pulse
mem_rw  out  1  memory write enable; registered
mem_addr  out  ADDR_W  memory byte address
mem_data  inout  64  driven by this block only while mem_rw=1, otherwise high-Z

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_rw=0; mem_addr=0; mem_data high-Z; all ready, rsp and err = 0; rdata=0; rr_ptr=0 (port 0 favoured). Reset mid-operation aborts the access; no partial write may follow.
- States: IDLE, RD, WR, DONE.
- IDLE, arbitration:
  - If exactly one port is valid, grant it.
  - If both are valid, grant the port favoured by rr_ptr, then set rr_ptr to the other port.
  - Pulse ready of the granted port only. Latch we, size, sext, addr and wdata.
- Range check at grant: if addr+nbytes > MEM_BYTES, go straight to DONE with err=1. No memory cycle is issued and the memory is unchanged.
- Transitions from IDLE:
  - load -> RD
  - store with size=3 -> WR
  - store with size<3 -> RD, then WR
- RD (1 cycle): mem_addr=addr, mem_rw=0. Capture the memory word rd at the rising edge that ends RD.
- WR (1 cycle): mem_addr=addr, mem_rw=1, mem_data=wbus. The memory commits at the negedge inside WR. mem_rw returns to 0 at the next posedge.
- Store merge (k = nbytes×8): wbus = {wdata[k-1:0], rd[63-k:0]}.
  - Byte addr receives the most-significant byte of the k-bit value.
  - Bytes addr+nbytes .. addr+7 are rewritten with their unchanged values.
  - For size=3, wbus = wdata.
- Load result (k = nbytes×8): value = rd[63:64-k], zero-extended, or sign-extended from bit k-1 when sext=1.
- DONE (1 cycle): pulse rsp of the granted port. rdata is updated for loads only. err is set only for range faults. Next state is IDLE.
- Latency from the accept cycle T:
  - load: rsp at T+2
  - 8-byte store: rsp at T+2
  - sub-word store: rsp at T+3
  - range error: rsp at T+1
- Exactly one request is in flight at a time; ready is 0 outside IDLE.
- The block never drives mem_data when mem_rw=0. This is checked with an assertion.

Test Plan:
1. Port 0 8-byte store to addr 0x10 with wdata 0x0C3C3EAAF00FCC33, then an 8-byte load from 0x10 -> rdata=0x0C3C3EAAF00FCC33; memory byte 0x10=0x0C and byte 0x17=0x33; rsp timing as specified.
2. After test 1, 1-byte store of 0xA5 to 0x12, then 8-byte load from 0x10 -> 0x0C3CA5AAF00FCC33; the WR cycle is preceded by exactly one RD; rsp at T+3.
3. 2-byte load from 0x14 with sext=1 -> 0xFFFFFFFFFFFFF00F; same load with sext=0 -> 0x000000000000F00F.
4. Both ports valid for 4 consecutive requests -> grants alternate p0, p1, p0, p1; each ready pulses once per request; no port waits for more than one other request.
5. 8-byte load at addr MEM_BYTES-7 -> err=1 at T+1, no mem_rw pulse. 1-byte store at MEM_BYTES-1 -> legal, the last byte is written.
6. Assert rst=0 during the WR of a sub-word store, before the negedge -> mem_rw=0 immediately, mem_data high-Z, memory unchanged; after release, state=IDLE and the next request is served normally.
